// File: rtl/rst_src_ctrl.sv
// Reset-source controller: merges a debounced button, watchdog and software requests
// into one registered active-low reset pulse with a minimum width and a sticky cause register.
module rst_src_ctrl #(
    parameter int DB_CNT       = 1000000,
    parameter int PULSE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n_i,
    input  logic       wdg_rst_req_i,
    input  logic       sw_rst_req_i,
    input  logic       cause_clr_i,
    output logic       rst_ext_n_o,
    output logic [3:0] rst_cause_o,
    output logic       busy_o
);

    localparam int              PW         = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0]   PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [19:0]     DB_LAST    = 20'(DB_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSERT   = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic [19:0]   r_db_cnt;
    logic          r_stable;
    logic          r_stable_prev;

    state_t        r_state;
    logic [PW-1:0] r_pulse_cnt;
    logic [3:0]    r_cause;
    logic          r_rst_n;

    state_t        w_state_next;
    logic [PW-1:0] w_pulse_cnt_next;
    logic [3:0]    w_cause_next;
    logic          w_press;
    logic [2:0]    w_req;
    logic          w_any_req;

    // Both sync flops idle high so a released button never looks like a press at power-on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt      <= '0;
            r_stable      <= 1'b1;
            r_stable_prev <= 1'b1;
        end else begin
            r_stable_prev <= r_stable;
            if (r_sync2 != r_stable) begin
                if (r_db_cnt == DB_LAST) begin
                    r_stable <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 20'd1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press   = r_stable_prev & ~r_stable;
    assign w_req     = {sw_rst_req_i, wdg_rst_req_i, w_press};
    assign w_any_req = |w_req;

    always_comb begin
        w_state_next     = r_state;
        w_pulse_cnt_next = r_pulse_cnt;
        w_cause_next     = r_cause;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next     = S_ASSERT;
                    w_pulse_cnt_next = '0;
                    w_cause_next     = {1'b0, w_req};
                end else if (cause_clr_i) begin
                    w_cause_next = 4'b0000;
                end
            end
            S_ASSERT: begin
                // Late requests only record their cause; the pulse is not restarted.
                w_cause_next = r_cause | {1'b0, w_req};
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_pulse_cnt_next = '0;
                    w_state_next     = r_stable ? S_IDLE : S_WAIT_REL;
                end else begin
                    w_pulse_cnt_next = r_pulse_cnt + 1'b1;
                end
            end
            S_WAIT_REL: begin
                w_cause_next = r_cause | {1'b0, w_req};
                if (r_stable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next     = S_ASSERT;
                w_pulse_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_ASSERT;
            r_pulse_cnt <= '0;
            r_cause     <= 4'b1000;
            r_rst_n     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_cause     <= w_cause_next;
            r_rst_n     <= (w_state_next == S_IDLE);
        end
    end

    assign rst_ext_n_o = r_rst_n;
    assign rst_cause_o = r_cause;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rst_src_ctrl.sv
// Directed bench for rst_src_ctrl with DB_CNT=4, PULSE_CYCLES=8.
module tb_rst_src_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_n_i;
    logic       wdg_rst_req_i;
    logic       sw_rst_req_i;
    logic       cause_clr_i;
    logic       rst_ext_n_o;
    logic [3:0] rst_cause_o;
    logic       busy_o;

    int total;
    int bad;

    rst_src_ctrl #(
        .DB_CNT      (4),
        .PULSE_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n_i      (btn_n_i),
        .wdg_rst_req_i(wdg_rst_req_i),
        .sw_rst_req_i (sw_rst_req_i),
        .cause_clr_i  (cause_clr_i),
        .rst_ext_n_o  (rst_ext_n_o),
        .rst_cause_o  (rst_cause_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (rst_ext_n_o !== 1'b0 || busy_o !== 1'b1 || rst_cause_o !== 4'b1000) begin
            bad++;
            $display("FAIL por_hold: rst_n=%b busy=%b cause=%b want 0 1 1000", rst_ext_n_o, busy_o, rst_cause_o);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (rst_ext_n_o !== (i == 8) || busy_o !== (i < 8) || rst_cause_o !== 4'b1000) begin
                bad++;
                $display("FAIL por_release[%0d]: rst_n=%b busy=%b cause=%b want %b %b 1000",
                         i, rst_ext_n_o, busy_o, rst_cause_o, (i == 8), (i < 8));
            end
        end
        $display("por sequence: cause=%b", rst_cause_o);
    endtask

    task automatic test_sw();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        total++;
        if (rst_ext_n_o !== 1'b0 || busy_o !== 1'b1 || rst_cause_o !== 4'b0100) begin
            bad++;
            $display("FAIL sw_start: rst_n=%b busy=%b cause=%b want 0 1 0100", rst_ext_n_o, busy_o, rst_cause_o);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (rst_ext_n_o !== (i == 8)) begin
                bad++;
                $display("FAIL sw_pulse[%0d]: rst_n=%b want %b", i, rst_ext_n_o, (i == 8));
            end
        end
        $display("sw reset: cause=%b", rst_cause_o);
    endtask

    task automatic test_btn_glitch();
        btn_n_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        btn_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rst_ext_n_o !== 1'b1 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL btn_glitch[%0d]: rst_n=%b busy=%b want 1 0", i, rst_ext_n_o, busy_o);
            end
        end
        $display("button glitch: cause=%b", rst_cause_o);
    endtask

    // Button low sampled at edges 0..9; press event lands at edge 6, release
    // propagates through sync+debounce so the reset ends at edge 16.
    task automatic test_btn_press();
        btn_n_i = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            tick();
            if (i == 9) btn_n_i = 1'b1;
            total++;
            if (rst_ext_n_o !== (i < 6 || i >= 16)) begin
                bad++;
                $display("FAIL btn_press[%0d]: rst_n=%b want %b", i, rst_ext_n_o, (i < 6 || i >= 16));
            end
            if (i == 6) begin
                total++;
                if (rst_cause_o !== 4'b0001) begin
                    bad++;
                    $display("FAIL btn_cause: cause=%b want 0001", rst_cause_o);
                end
            end
        end
        for (int i = 0; i < 3; i++) tick();
        $display("button press: cause=%b", rst_cause_o);
    endtask

    task automatic test_btn_hold();
        btn_n_i = 1'b0;
        for (int i = 0; i <= 48; i++) begin
            tick();
            if (i == 39) btn_n_i = 1'b1;
            total++;
            if (rst_ext_n_o !== (i < 6 || i >= 46)) begin
                bad++;
                $display("FAIL btn_hold[%0d]: rst_n=%b want %b", i, rst_ext_n_o, (i < 6 || i >= 46));
            end
        end
        total++;
        if (rst_cause_o !== 4'b0001 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL btn_hold_end: cause=%b busy=%b want 0001 0", rst_cause_o, busy_o);
        end
        $display("button hold: cause=%b", rst_cause_o);
    endtask

    task automatic test_simultaneous();
        wdg_rst_req_i = 1'b1;
        sw_rst_req_i  = 1'b1;
        tick();
        wdg_rst_req_i = 1'b0;
        sw_rst_req_i  = 1'b0;
        total++;
        if (rst_cause_o !== 4'b0110 || rst_ext_n_o !== 1'b0) begin
            bad++;
            $display("FAIL simul_cause: cause=%b rst_n=%b want 0110 0", rst_cause_o, rst_ext_n_o);
        end
        for (int i = 0; i < 8; i++) tick();
        cause_clr_i   = 1'b1;
        wdg_rst_req_i = 1'b1;
        tick();
        cause_clr_i   = 1'b0;
        wdg_rst_req_i = 1'b0;
        total++;
        if (rst_cause_o !== 4'b0010 || rst_ext_n_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_vs_wdg: cause=%b rst_n=%b want 0010 0", rst_cause_o, rst_ext_n_o);
        end
        for (int i = 0; i < 8; i++) tick();
        cause_clr_i = 1'b1;
        tick();
        cause_clr_i = 1'b0;
        total++;
        if (rst_cause_o !== 4'b0000 || rst_ext_n_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone: cause=%b rst_n=%b busy=%b want 0000 1 0", rst_cause_o, rst_ext_n_o, busy_o);
        end
        $display("simultaneous/clear: cause=%b", rst_cause_o);
    endtask

    task automatic test_req_in_assert();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) wdg_rst_req_i = 1'b1;
            tick();
            wdg_rst_req_i = 1'b0;
            total++;
            if (rst_ext_n_o !== (i == 8)) begin
                bad++;
                $display("FAIL assert_req_pulse[%0d]: rst_n=%b want %b", i, rst_ext_n_o, (i == 8));
            end
            total++;
            if (rst_cause_o !== ((i < 4) ? 4'b0100 : 4'b0110)) begin
                bad++;
                $display("FAIL assert_req_cause[%0d]: cause=%b want %b", i, rst_cause_o,
                         ((i < 4) ? 4'b0100 : 4'b0110));
            end
        end
        $display("request during assert: cause=%b", rst_cause_o);
    endtask

    task automatic test_rst_mid_pulse();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        total++;
        if (rst_cause_o !== 4'b1000 || rst_ext_n_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: cause=%b rst_n=%b busy=%b want 1000 0 1", rst_cause_o, rst_ext_n_o, busy_o);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (rst_ext_n_o !== (i == 8)) begin
                bad++;
                $display("FAIL rst_mid_pulse[%0d]: rst_n=%b want %b", i, rst_ext_n_o, (i == 8));
            end
        end
        $display("rst mid-pulse: cause=%b", rst_cause_o);
    endtask

    task automatic test_back_to_back();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        wdg_rst_req_i = 1'b1;
        tick();
        wdg_rst_req_i = 1'b0;
        total++;
        if (rst_ext_n_o !== 1'b0 || rst_cause_o !== 4'b0010) begin
            bad++;
            $display("FAIL back_to_back: rst_n=%b cause=%b want 0 0010", rst_ext_n_o, rst_cause_o);
        end
        for (int i = 0; i < 8; i++) tick();
        $display("back to back: cause=%b", rst_cause_o);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        btn_n_i       = 1'b1;
        wdg_rst_req_i = 1'b0;
        sw_rst_req_i  = 1'b0;
        cause_clr_i   = 1'b0;
        test_reset();
        test_sw();
        test_btn_glitch();
        test_btn_press();
        test_btn_hold();
        test_simultaneous();
        test_req_in_assert();
        test_rst_mid_pulse();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_src_ctrl.md
# rst_src_ctrl

Reset-source controller sitting directly upstream of the core reset control block. It merges a debounced external reset button, a watchdog reset request and a software reset request into one active-low external reset (`rst_ext_n_o`), which drives the reset control block's external reset input. It enforces a minimum reset pulse width and keeps a sticky reset-cause register that survives the resets it generates, so software can read why the last reset happened.

## Interface
- `DB_CNT`, default 1000000: debounce length in clk cycles (20 ms at 50 MHz); 1..2^20.
- `PULSE_CYCLES`, default 16: minimum `rst_ext_n_o` low width in cycles; 1..256.
- `clk` in 1: system clock.
- `rst` in 1: power-on reset. Asynchronous, active-high (fixed).
- `btn_n_i` in 1: raw external reset button, active-low, asynchronous to `clk`.
- `wdg_rst_req_i` in 1: watchdog reset request, synchronous, sampled only when high.
- `sw_rst_req_i` in 1: software reset request, synchronous one-cycle pulse.
- `cause_clr_i` in 1: clears the cause register, synchronous.
- `rst_ext_n_o` out 1: active-low reset to the reset control block; registered.
- `rst_cause_o` out 4: sticky cause bits `{por, sw, wdg, btn}` = bits [3:0].
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- **Button synchronizer.** `btn_n_i` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Debounce.**
  - A 20-bit counter increments while the synced value differs from `stable`. It clears whenever they match.
  - When the counter reaches DB_CNT-1 and still differs, `stable` takes the synced value and the counter clears.
  - `stable` resets to 1.
  - A press event is a 1->0 transition of `stable`.
- **FSM states:** IDLE, ASSERT, WAIT_REL. The reset state is ASSERT with counter 0 and cause 4'b1000 (por).
- **IDLE**
  - Any of {press event, `wdg_rst_req_i`, `sw_rst_req_i`} -> ASSERT and the counter clears.
  - The cause register is overwritten with exactly the set of requests present that cycle; simultaneous requests set several bits.
  - `cause_clr_i` with no request clears cause to 0. If a request arrives in the same cycle, the request wins.
- **ASSERT**
  - The counter increments each cycle.
  - At counter == PULSE_CYCLES-1: go to IDLE if `stable`==1, else go to WAIT_REL.
- **WAIT_REL**
  - Stay while `stable`==0, so a held button keeps the system in reset.
  - Go to IDLE when `stable`==1.
- **Requests in ASSERT/WAIT_REL** are OR-ed into the cause register and do not restart the pulse. `cause_clr_i` is ignored in these states.
- **Outputs.** `rst_ext_n_o` is registered as (next_state == IDLE). `busy_o` = (state != IDLE). `rst_cause_o` is driven directly by the cause register.
- **Power-on with the button held.** `stable` falls only after the debounce time, which produces a press event. If that event arrives in IDLE it causes a second reset.
- The cause register is reset only by `rst`, never by `rst_ext_n_o`.

## Timing
- **While `rst` is high:** `rst_ext_n_o`=0, `busy_o`=1, `rst_cause_o`=4'b1000, `stable`=1, counters 0.
- **POR release:** `rst_ext_n_o` stays low for exactly PULSE_CYCLES rising edges after `rst` falls, then goes 1 (button released).
- **Request latency:** a request sampled in IDLE at edge k drives `rst_ext_n_o` low at edge k. It stays low for exactly PULSE_CYCLES cycles, or longer while the button is held.
- **Button latency:** from the `btn_n_i` edge to the press event is 2 (sync) + DB_CNT cycles.
- **Glitch rejection:** button glitches shorter than DB_CNT cycles never change `stable`.
- **`rst` mid-operation:** asserting `rst` at any time forces the reset values asynchronously, and the POR sequence restarts on release.

## Test plan
All scenarios use DB_CNT=4, PULSE_CYCLES=8.
- **POR:** `rst` high 3 cycles, then low -> `rst_ext_n_o`=0 for 8 cycles, then 1; `rst_cause_o`=4'b1000; `busy_o` falls with the release.
- **Software reset:** one-cycle `sw_rst_req_i` in IDLE -> `rst_ext_n_o` low the same edge for 8 cycles; `rst_cause_o`=4'b0100.
- **Button:**
  - Low for 3 cycles -> no reset.
  - Low for 10 cycles -> reset begins 6 cycles after the fall; cause 4'b0001.
  - Held low for 40 cycles -> `rst_ext_n_o` stays low until 6 cycles after release.
- **Simultaneous requests:** `wdg_rst_req_i` and `sw_rst_req_i` in the same cycle -> cause 4'b0110.
  - `cause_clr_i` together with `wdg_rst_req_i` -> cause 4'b0010.
  - `cause_clr_i` alone in IDLE -> cause 0.
- **Request during ASSERT:** `wdg_rst_req_i` at pulse cycle 4 -> pulse still ends at cycle 8; cause gains the wdg bit.
- **`rst` mid-pulse:** `rst` asserted at ASSERT cycle 5 -> cause 4'b1000 immediately; after release a full 8-cycle pulse.
